base_evt_drain: RTL

- Consumer end of a sticky set/reset event vector.
- Captures single-cycle event pulses into per-bit pending flags.
- Reports each pending bit, one at a time and in round-robin order, as a tag on a valid/ready output stream.
- Clears a bit only when the downstream consumer accepts its tag. Used by interrupt and error reporting paths to serialize event vectors toward a single handler.

---
 rtl/base_evt_drain_pkg.sv | 4 +
 rtl/base_evt_drain_rr_pick.sv | 35 +++
 rtl/base_evt_drain.sv | 102 ++++++++++
 3 files changed

// File: rtl/base_evt_drain_pkg.sv
// Shared types for the event-drain slice: output state machine encoding.
package base_evt_drain_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} drain_st_t;
endpackage

// File: rtl/base_evt_drain_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping width-1 -> 0.
module base_rr_pick #(
  parameter int width = 8,
  parameter int tagw  = 3
) (
  input  logic [0:width-1] req,
  input  logic [0:tagw-1]  ptr,
  output logic             any,
  output logic [0:tagw-1]  idx
);

  function automatic logic [0:tagw-1] wrap_add(input logic [0:tagw-1] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= width) s = s - width;
    return tagw'(s);
  endfunction

  logic [0:tagw-1] j;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = width - 1; k >= 0; k--) begin
      j = wrap_add(ptr, k);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/base_evt_drain.sv
// Sticky event vector drain: serializes pending event bits as round-robin tags.
// Optional overflow tracking of coalesced events under BASE_EVT_DRAIN_OVF_EN.
module base_evt_drain
  import base_evt_drain_pkg::*;
#(
  parameter int width = 8,
  parameter int tagw  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:width-1] set,
  output logic             o_v,
  input  logic             o_r,
  output logic [0:tagw-1]  o_tag,
  output logic [0:width-1] pending
`ifdef BASE_EVT_DRAIN_OVF_EN
  ,
  output logic [0:width-1] o_ovf,
  output logic             o_tag_ovf
`endif
);

  drain_st_t        st;
  logic             hs;
  logic [0:width-1] clr;
  logic [0:width-1] cand;
  logic [0:tagw-1]  ptr;
  logic [0:tagw-1]  ptr_nxt;
  logic             pick_any;
  logic [0:tagw-1]  pick_idx;

  assign hs = o_v & o_r;

  always_comb begin
    clr = '0;
    for (int i = 0; i < width; i++)
      clr[i] = hs && (o_tag == tagw'(i));
  end

  // Bits pulsed this cycle are not candidates until they land in pending.
  assign cand = pending & ~clr;

  always_comb begin
    ptr_nxt = ptr;
    if (hs)
      ptr_nxt = (o_tag == tagw'(width - 1)) ? '0 : o_tag + tagw'(1);
  end

  base_rr_pick #(.width(width), .tagw(tagw)) u_pick (
    .req (cand),
    .ptr (ptr_nxt),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= ST_IDLE;
      o_v     <= 1'b0;
      o_tag   <= '0;
      ptr     <= '0;
      pending <= '0;
    end else begin
      pending <= set | cand;
      ptr     <= ptr_nxt;
      case (st)
        ST_IDLE: begin
          if (pick_any) begin
            st    <= ST_PRESENT;
            o_v   <= 1'b1;
            o_tag <= pick_idx;
          end
        end
        ST_PRESENT: begin
          if (o_r) begin
            if (pick_any) begin
              o_tag <= pick_idx;
            end else begin
              st  <= ST_IDLE;
              o_v <= 1'b0;
            end
          end
        end
        default: begin
          st  <= ST_IDLE;
          o_v <= 1'b0;
        end
      endcase
    end
  end

`ifdef BASE_EVT_DRAIN_OVF_EN
  // A pulse landing on a bit that is already pending and not being drained is a lost event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_ovf <= '0;
    else       o_ovf <= (set & cand) | (o_ovf & ~clr);
  end

  assign o_tag_ovf = o_v & o_ovf[o_tag];
`endif

endmodule
